rr_decode_arbiter: RTL
======================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 8-way decoded resource (3-bit select plus enable, producing 8 one-hot lines) among 8 requesters.
- Picks one requester at a time and holds the grant until the requester releases it or a hold timeout expires.
- Drives both the encoded index and the registered one-hot grant.
- Sits between requesting agents and the decoder-selected resource. Only one line is ever active; the enable is deasserted between owners.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 in this revision (IDX_W = 3).
- IDX_W, 3, width of encoded grant index.
- MAX_HOLD, 16, maximum cycles one owner may hold the grant before forced release; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request per requester, level; held high until served.
- done  in  8  release pulse per requester; only the bit of the current owner is honoured.
- grant  out  8  registered one-hot grant, all zero when no owner.
- grant_idx  out  3  encoded index of the owner; holds last value when grant_vld = 0.
- grant_vld  out  1  high while any grant bit is high; this is the decoder enable.
- timeout  out  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (async, rst_n = 0):
  - grant = 0, grant_idx = 0, grant_vld = 0, timeout = 0.
  - State = IDLE, hold counter = 0, priority pointer last = 7, so requester 0 wins first.
- All state updates occur on the rising edge of clk; rst_n deassertion is sampled normally.
- FSM states: IDLE, BUSY, GAP.
- IDLE:
  - If req != 0, select the first set bit searching last+1, last+2, ... modulo 8.
  - Next edge: grant = onehot(sel), grant_idx = sel, grant_vld = 1, last = sel, counter = 0, state = BUSY.
  - If req == 0, stay in IDLE with outputs zero.
- Latency: req rising in IDLE at edge k is granted at edge k+1 (one cycle).
- BUSY (owner o = grant_idx):
  - counter increments each cycle, saturating at MAX_HOLD.
  - Release conditions, evaluated each cycle in priority order:
    - (a) done[o] = 1: normal release.
    - (b) req[o] = 0: abandon, no timeout.
    - (c) counter == MAX_HOLD-1: forced release; timeout pulses 1 on the same edge that clears grant.
  - On release: grant = 0, grant_vld = 0, state = GAP.
  - done and timeout in the same cycle: done wins, timeout stays 0.
  - done bits for non-owners are ignored; other req changes are ignored while BUSY.
- GAP: exactly one cycle with grant_vld = 0 (break-before-make on the decoded lines), then IDLE. No arbitration is performed in GAP.
- Worst-case turnaround between owners: release edge, GAP, IDLE evaluation; the new grant appears 2 edges after release.
- Fairness:
  - A requester that was just served has lowest priority next round.
  - With all 8 requesting continuously, grants cycle 0,1,...,7,0.
- Wrap-around: the search from last = 7 starts at 0; from last = 5 the order is 6,7,0,...,5.
- Single requester: the same index may be re-granted after GAP if its req is still high.
- Reset mid-BUSY: grant drops asynchronously, no timeout pulse, pointer returns to 7.
- Invariant: $onehot0(grant) always; grant_vld == |grant; grant[grant_idx] == grant_vld.

Decomposition:
- Package rr_decode_pkg:
  - IDX_W, N_REQ constants.
  - State enum typedef {IDLE, BUSY, GAP}.
  - Function next_rr(req, last) returning the index.
- One sub-module, idx_to_onehot:
  - 3-bit index plus enable in, 8-bit one-hot out.
  - Combinational; its output is registered in the arbiter.

Test Plan:
- Reset release, req = 8'b0000_0001 held, done[0] pulsed at cycle 3 -> grant = 8'h01 from cycle 1; grant = 0 at cycle 4; GAP; regrant 8'h01 at cycle 6.
- req = 8'hFF constant, each owner pulses done one cycle after grant -> grant_idx sequence 0,1,2,...,7,0; one zero cycle between grants; never two bits high.
- MAX_HOLD = 16, req[3] high only, done never asserted -> grant = 8'h08 for 16 cycles; timeout = 1 for one cycle as grant clears; regrant after GAP.
- Owner 2 asserts done[2] on the same cycle the counter hits MAX_HOLD-1 -> release with timeout = 0.
- Owner 5 active, done[6] and req[6] pulsed -> no effect; then req[5] dropped -> release with no timeout; next grant goes to 6 (search 6,7,0,...).
- rst_n pulled low mid-BUSY with owner 4 -> grant = 0 immediately, timeout = 0; after release with req = 8'h30, grant goes to 4 (pointer reset to 7).

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// Holds the FSM encoding and the rotating-priority search.
package rr_decode_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_e;

  // First set request after `last`, wrapping; `last` itself is checked last.
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] res;
    logic             found;
    res   = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + IDX_W'(i);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between requesting agents and the arbiter.
// master = requesters, slave = arbiter.
interface rr_decode_arbiter_if;
  import rr_decode_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_vld, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_vld, timeout
  );

endinterface

// File: rtl/rr_decode_arbiter_idx_to_onehot.sv
// 3-bit index plus enable to 8-line one-hot decoder.
// Purely combinational; the arbiter registers the result.
module idx_to_onehot
  import rr_decode_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for one 8-way decoded resource.
// Holds each grant until done, abandon or hold timeout.
module rr_decode_arbiter
  import rr_decode_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decode_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             vld_q;
  logic             to_q;
  logic [7:0]       cnt_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] sel_d;
  logic [N_REQ-1:0] oh_d;
  logic             arb_d;
  logic             own_done;
  logic             own_req;
  logic             hold_end;

  assign sel_d    = next_rr(bus.req, last_q);
  assign arb_d    = (state_q == IDLE) && (|bus.req);
  assign own_done = bus.done[idx_q];
  assign own_req  = bus.req[idx_q];
  assign hold_end = (cnt_q == HOLD_LAST);

  idx_to_onehot u_dec (
    .idx_i (sel_d),
    .en_i  (arb_d),
    .oh_o  (oh_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_d) begin
            grant_q <= oh_d;
            idx_q   <= sel_d;
            vld_q   <= 1'b1;
            last_q  <= sel_d;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (own_done || !own_req || hold_end) begin
            grant_q <= '0;
            vld_q   <= 1'b0;
            state_q <= GAP;
            // Only a pure hold expiry counts as a forced release.
            to_q    <= hold_end && !own_done && own_req;
          end else if (cnt_q != HOLD_MAX) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GAP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.grant_vld = vld_q;
  assign bus.timeout   = to_q;

endmodule
